// File: rtl/mem_port_pkg.sv
// Shared types and exception codes for the memory port responder.
// Holds the FSM state type, the request kind and the latched-request record.
package mem_port_pkg;

    localparam logic [3:0] EXC_IMIS   = 4'd0;
    localparam logic [3:0] EXC_IFAULT = 4'd1;
    localparam logic [3:0] EXC_LMIS   = 4'd4;
    localparam logic [3:0] EXC_LFAULT = 4'd5;
    localparam logic [3:0] EXC_SMIS   = 4'd6;
    localparam logic [3:0] EXC_SFAULT = 4'd7;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    typedef enum logic [1:0] {K_FETCH, K_READ, K_WRITE} req_kind_t;

    typedef struct packed {
        req_kind_t   kind;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        lr;
        logic        exc;
        logic [3:0]  code;
        logic        sc_fail;
    } req_t;

    function automatic logic [3:0] mis_code(input req_kind_t k);
        case (k)
            K_READ:  mis_code = EXC_LMIS;
            K_WRITE: mis_code = EXC_SMIS;
            default: mis_code = EXC_IMIS;
        endcase
    endfunction

    function automatic logic [3:0] fault_code(input req_kind_t k);
        case (k)
            K_READ:  fault_code = EXC_LFAULT;
            K_WRITE: fault_code = EXC_SFAULT;
            default: fault_code = EXC_IFAULT;
        endcase
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Fixed-priority grant (store > load > fetch) among the three request ports.
// Grants only while the responder is idle; readies are purely combinational.
module mem_port_arbiter
    import mem_port_pkg::*;
(
    input  logic      idle,
    input  logic      fetch_enable,
    input  logic      rd_enable,
    input  logic      wr_enable,
    output logic      fetch_ready,
    output logic      rd_ready,
    output logic      wr_ready,
    output logic      grant_any,
    output req_kind_t grant_kind
);

    always_comb begin
        wr_ready    = idle && wr_enable;
        rd_ready    = idle && rd_enable && !wr_enable;
        fetch_ready = idle && fetch_enable && !wr_enable && !rd_enable;
        grant_any   = wr_ready || rd_ready || fetch_ready;
        grant_kind  = K_FETCH;
        if (wr_ready)
            grant_kind = K_WRITE;
        else if (rd_ready)
            grant_kind = K_READ;
    end

endmodule

// File: rtl/mem_port_responder.sv
// Memory-side responder: arbitrates fetch/load/store onto one synchronous SRAM,
// reports alignment/range exceptions and tracks a single LR/SC reservation.
module mem_port_responder
    import mem_port_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 16384,
    parameter int unsigned IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             fetch_enable,
    input  logic [31:0]      fetch_address,
    output logic             fetch_ready,
    output logic             fetch_valid,
    output logic [31:0]      fetch_inst,
    output logic             fetch_exc_valid,
    output logic [3:0]       fetch_exc_code,
    output logic [31:0]      fetch_exc_value,
    input  logic             rd_enable,
    input  logic [31:0]      rd_address,
    input  logic             rd_lr,
    output logic             rd_ready,
    output logic             rd_valid,
    output logic [31:0]      rd_data,
    output logic [1:0]       rd_reservation,
    output logic             rd_exc_valid,
    output logic [3:0]       rd_exc_code,
    input  logic             wr_enable,
    input  logic [31:0]      wr_address,
    input  logic [31:0]      wr_data,
    input  logic             wr_sc,
    output logic             wr_ready,
    output logic             wr_valid,
    output logic             wr_sc_fail,
    output logic             wr_exc_valid,
    output logic [3:0]       wr_exc_code,
    output logic             sram_en,
    output logic             sram_we,
    output logic [IDX_W-1:0] sram_addr,
    output logic [31:0]      sram_wdata,
    input  logic [31:0]      sram_rdata
);

    state_t           state, state_nxt;
    req_t             req_q, req_nxt;
    logic             grant_any;
    req_kind_t        grant_kind;
    logic [31:0]      sel_addr;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_mis, sel_oor, sel_sc;
    logic             res_valid;
    logic [IDX_W-1:0] res_idx;
    logic [31:0]      inst_q, rdata_q;
    logic             resp_fetch_ok, resp_rd_ok;

    // RESET gates the idle qualifier so no ready can show while held in reset.
    mem_port_arbiter u_arb (
        .idle         (state == IDLE && RESET),
        .fetch_enable (fetch_enable),
        .rd_enable    (rd_enable),
        .wr_enable    (wr_enable),
        .fetch_ready  (fetch_ready),
        .rd_ready     (rd_ready),
        .wr_ready     (wr_ready),
        .grant_any    (grant_any),
        .grant_kind   (grant_kind)
    );

    // Range math is 33 bits wide so BASE_ADDR + 4*MEM_WORDS cannot wrap.
    always_comb begin
        case (grant_kind)
            K_WRITE: sel_addr = wr_address;
            K_READ:  sel_addr = rd_address;
            default: sel_addr = fetch_address;
        endcase
        sel_mis = sel_addr[1:0] != 2'b00;
        sel_oor = ({1'b0, sel_addr} < {1'b0, BASE_ADDR}) ||
                  ({1'b0, sel_addr} >= ({1'b0, BASE_ADDR} + 33'(MEM_WORDS) * 33'd4));
        sel_idx = IDX_W'(({1'b0, sel_addr} - {1'b0, BASE_ADDR}) >> 2);
        sel_sc  = (grant_kind == K_WRITE) && wr_sc;

        req_nxt         = '0;
        req_nxt.kind    = grant_kind;
        req_nxt.addr    = sel_addr;
        req_nxt.wdata   = wr_data;
        req_nxt.lr      = (grant_kind == K_READ) && rd_lr;
        req_nxt.exc     = sel_mis || sel_oor;
        req_nxt.code    = sel_mis ? mis_code(grant_kind) : fault_code(grant_kind);
        req_nxt.sc_fail = sel_sc && !req_nxt.exc && !(res_valid && res_idx == sel_idx);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_any) state_nxt = (req_nxt.exc || req_nxt.sc_fail) ? RESP : ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            req_q     <= '0;
            res_valid <= 1'b0;
            res_idx   <= '0;
            inst_q    <= '0;
            rdata_q   <= '0;
        end else begin
            if (grant_any) begin
                req_q <= req_nxt;
                if (req_nxt.lr && !req_nxt.exc) begin
                    res_valid <= 1'b1;
                    res_idx   <= sel_idx;
                end else if (sel_sc) begin
                    res_valid <= 1'b0;
                end else if (grant_kind == K_WRITE && !req_nxt.exc && res_idx == sel_idx) begin
                    res_valid <= 1'b0;
                end
            end
            if (resp_fetch_ok)
                inst_q <= sram_rdata;
            if (resp_rd_ok)
                rdata_q <= sram_rdata;
        end
    end

    // Data outputs pass sram_rdata through during the response and hold it afterwards.
    always_comb begin
        sram_en    = state == ACCESS;
        sram_we    = sram_en && req_q.kind == K_WRITE;
        sram_addr  = sram_en ? IDX_W'(({1'b0, req_q.addr} - {1'b0, BASE_ADDR}) >> 2) : '0;
        sram_wdata = sram_we ? req_q.wdata : '0;

        fetch_valid     = state == RESP && req_q.kind == K_FETCH;
        fetch_exc_valid = fetch_valid && req_q.exc;
        fetch_exc_code  = fetch_exc_valid ? req_q.code : '0;
        fetch_exc_value = fetch_exc_valid ? req_q.addr : '0;
        resp_fetch_ok   = fetch_valid && !req_q.exc;
        fetch_inst      = resp_fetch_ok ? sram_rdata : inst_q;

        rd_valid       = state == RESP && req_q.kind == K_READ;
        rd_exc_valid   = rd_valid && req_q.exc;
        rd_exc_code    = rd_exc_valid ? req_q.code : '0;
        resp_rd_ok     = rd_valid && !req_q.exc;
        rd_data        = resp_rd_ok ? sram_rdata : rdata_q;
        rd_reservation = (resp_rd_ok && req_q.lr) ? 2'b01 : 2'b00;

        wr_valid     = state == RESP && req_q.kind == K_WRITE;
        wr_exc_valid = wr_valid && req_q.exc;
        wr_exc_code  = wr_exc_valid ? req_q.code : '0;
        wr_sc_fail   = wr_valid && req_q.sc_fail;
    end

endmodule

// File: tb/tb_mem_port_responder.sv
// Randomized and directed bench for mem_port_responder against a transaction-level model.
module tb_mem_port_responder;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int unsigned WORDS = 16384;
    localparam int KF = 0;
    localparam int KR = 1;
    localparam int KW = 2;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        fetch_enable = 1'b0, rd_enable = 1'b0, wr_enable = 1'b0;
    logic [31:0] fetch_address = '0, rd_address = '0, wr_address = '0, wr_data = '0;
    logic        rd_lr = 1'b0, wr_sc = 1'b0;
    logic        fetch_ready, fetch_valid, fetch_exc_valid;
    logic [31:0] fetch_inst, fetch_exc_value;
    logic [3:0]  fetch_exc_code, rd_exc_code, wr_exc_code;
    logic        rd_ready, rd_valid, rd_exc_valid;
    logic [31:0] rd_data;
    logic [1:0]  rd_reservation;
    logic        wr_ready, wr_valid, wr_sc_fail, wr_exc_valid;
    logic        sram_en, sram_we;
    logic [13:0] sram_addr;
    logic [31:0] sram_wdata, sram_rdata;

    logic [31:0] tb_sram [WORDS];
    logic [31:0] ref_mem [WORDS];
    logic        ref_res_v;
    int          ref_res_idx;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 CLK = ~CLK;

    mem_port_responder #(.BASE_ADDR(BASE), .MEM_WORDS(WORDS), .IDX_W(14)) dut (
        .CLK(CLK), .RESET(RESET),
        .fetch_enable(fetch_enable), .fetch_address(fetch_address), .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid), .fetch_inst(fetch_inst), .fetch_exc_valid(fetch_exc_valid),
        .fetch_exc_code(fetch_exc_code), .fetch_exc_value(fetch_exc_value),
        .rd_enable(rd_enable), .rd_address(rd_address), .rd_lr(rd_lr), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_reservation(rd_reservation),
        .rd_exc_valid(rd_exc_valid), .rd_exc_code(rd_exc_code),
        .wr_enable(wr_enable), .wr_address(wr_address), .wr_data(wr_data), .wr_sc(wr_sc),
        .wr_ready(wr_ready), .wr_valid(wr_valid), .wr_sc_fail(wr_sc_fail),
        .wr_exc_valid(wr_exc_valid), .wr_exc_code(wr_exc_code),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    // SRAM macro stand-in: registered read, write on strobe.
    always @(posedge CLK) begin
        if (sram_en) begin
            if (sram_we) tb_sram[sram_addr] <= sram_wdata;
            else         sram_rdata <= tb_sram[sram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Transaction-level model: exception rules, reservation and memory contents.
    task automatic ref_step(input int k, input logic [31:0] a, input logic [31:0] d, input logic f,
                            output logic e_exc, output logic [3:0] e_code, output logic e_scf,
                            output logic [31:0] e_data);
        longint unsigned la;
        int idx;
        la = a;
        e_exc = 1'b0; e_code = 4'd0; e_scf = 1'b0; e_data = '0;
        if (la % 4 != 0) begin
            e_exc = 1'b1;
            e_code = (k == KF) ? 4'd0 : (k == KR) ? 4'd4 : 4'd6;
        end else if (la < BASE || la >= longint'(BASE) + 4 * longint'(WORDS)) begin
            e_exc = 1'b1;
            e_code = (k == KF) ? 4'd1 : (k == KR) ? 4'd5 : 4'd7;
        end
        if (!e_exc) begin
            idx = int'((la - BASE) / 4);
            if (k != KW) e_data = ref_mem[idx];
            if (k == KR && f) begin
                ref_res_v = 1'b1;
                ref_res_idx = idx;
            end
            if (k == KW) begin
                if (f) e_scf = !(ref_res_v && ref_res_idx == idx);
                if (!e_scf) ref_mem[idx] = d;
                if (f || ref_res_idx == idx) ref_res_v = 1'b0;
            end
        end else if (k == KW && f) begin
            ref_res_v = 1'b0;
        end
    endtask

    // Issue one request (entered just after a negedge) and check its full response.
    task automatic do_req(input int k, input logic [31:0] a, input logic [31:0] d,
                          input logic f, output int waited);
        logic e_exc, e_scf, rdy, vld, en_seen;
        logic [3:0] e_code;
        logic [31:0] e_data;
        int lat;
        ref_step(k, a, d, f, e_exc, e_code, e_scf, e_data);
        fetch_enable = (k == KF); fetch_address = a;
        rd_enable = (k == KR); rd_address = a; rd_lr = f;
        wr_enable = (k == KW); wr_address = a; wr_data = d; wr_sc = f;
        waited = 0; rdy = 1'b0;
        while (!rdy && waited < 20) begin
            #1;
            rdy = (k == KF) ? fetch_ready : (k == KR) ? rd_ready : wr_ready;
            if (!rdy) begin
                waited++;
                @(negedge CLK);
            end
        end
        check("grant", 32'(rdy), 32'd1);
        check("ready_onehot", 32'(fetch_ready) + 32'(rd_ready) + 32'(wr_ready), 32'd1);
        @(posedge CLK);
        #1;
        fetch_enable = 1'b0; rd_enable = 1'b0; wr_enable = 1'b0;
        lat = 0; en_seen = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge CLK);
            if (sram_en) en_seen = 1'b1;
            vld = (k == KF) ? fetch_valid : (k == KR) ? rd_valid : wr_valid;
            if (vld && lat == 0) begin
                lat = c;
                if (k == KF) begin
                    check("f_exc", 32'(fetch_exc_valid), 32'(e_exc));
                    check("f_code", 32'(fetch_exc_code), 32'(e_exc ? e_code : 4'd0));
                    if (e_exc) check("f_tval", fetch_exc_value, a);
                    else       check("f_inst", fetch_inst, e_data);
                end else if (k == KR) begin
                    check("r_exc", 32'(rd_exc_valid), 32'(e_exc));
                    check("r_code", 32'(rd_exc_code), 32'(e_exc ? e_code : 4'd0));
                    if (!e_exc) check("r_data", rd_data, e_data);
                    check("r_resv", 32'(rd_reservation), (f && !e_exc) ? 32'd1 : 32'd0);
                end else begin
                    check("w_exc", 32'(wr_exc_valid), 32'(e_exc));
                    check("w_code", 32'(wr_exc_code), 32'(e_exc ? e_code : 4'd0));
                    check("w_scfail", 32'(wr_sc_fail), 32'(e_scf));
                end
            end
        end
        check("latency", 32'(lat), (e_exc || e_scf) ? 32'd1 : 32'd2);
        check("sram_strobe", 32'(en_seen), 32'(!(e_exc || e_scf)));
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = int'($urandom_range(0, 9));
        if (r <= 5)      rand_addr = 32'h40 + 32'(4 * $urandom_range(0, 7));
        else if (r == 6) rand_addr = 32'h40 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(1, 3));
        else if (r == 7) rand_addr = 32'h0001_0000 + 32'(4 * $urandom_range(0, 100));
        else if (r == 8) rand_addr = 32'hFFFF_FFFC;
        else             rand_addr = {16'h0, $urandom_range(0, 16383) % 16384 == 0 ? 14'd0 : 14'($urandom_range(0, 16383)), 2'b00};
    endfunction

    initial begin
        int w, n, at [3], ord [3];
        logic multi, rseen, fseen, g_w, g_r, g_f, ex, sf;
        logic [3:0] cd;
        logic [31:0] dat, e2r, e2f, keep;
        int diffs;

        for (int i = 0; i < int'(WORDS); i++) begin
            tb_sram[i] = 32'(i) * 32'h0100_0193 ^ 32'hA5A5_0000;
            ref_mem[i] = tb_sram[i];
        end
        tb_sram[4] = 32'h0000_0013;
        ref_mem[4] = 32'h0000_0013;
        ref_res_v = 1'b0;
        ref_res_idx = 0;

        repeat (3) @(negedge CLK);
        check("reset_outs", 32'(|{fetch_ready, fetch_valid, fetch_inst, fetch_exc_valid, fetch_exc_code,
              fetch_exc_value, rd_ready, rd_valid, rd_data, rd_reservation, rd_exc_valid, rd_exc_code,
              wr_ready, wr_valid, wr_sc_fail, wr_exc_valid, wr_exc_code, sram_en, sram_we, sram_addr,
              sram_wdata}), 32'd0);
        RESET = 1'b1;

        do_req(KF, 32'h0000_0010, '0, 1'b0, w);
        check("first_grant_wait", 32'(w), 32'd0);

        // Simultaneous requests: store, then load, then fetch, three cycles apart.
        ref_step(KW, 32'h80, 32'hCAFE_0001, 1'b0, ex, cd, sf, dat);
        ref_step(KR, 32'h84, '0, 1'b0, ex, cd, sf, e2r);
        ref_step(KF, 32'h88, '0, 1'b0, ex, cd, sf, e2f);
        wr_enable = 1'b1; wr_address = 32'h80; wr_data = 32'hCAFE_0001; wr_sc = 1'b0;
        rd_enable = 1'b1; rd_address = 32'h84; rd_lr = 1'b0;
        fetch_enable = 1'b1; fetch_address = 32'h88;
        n = 0; multi = 1'b0; rseen = 1'b0; fseen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (32'(fetch_ready) + 32'(rd_ready) + 32'(wr_ready) > 1) multi = 1'b1;
            if (n < 3 && wr_ready)    begin ord[n] = KW; at[n] = c; n++; end
            if (n < 3 && rd_ready)    begin ord[n] = KR; at[n] = c; n++; end
            if (n < 3 && fetch_ready) begin ord[n] = KF; at[n] = c; n++; end
            if (rd_valid)    begin rseen = 1'b1; check("t2_rdata", rd_data, e2r); end
            if (fetch_valid) begin fseen = 1'b1; check("t2_inst", fetch_inst, e2f); end
            g_w = wr_ready; g_r = rd_ready; g_f = fetch_ready;
            @(posedge CLK);
            #1;
            if (g_w) wr_enable = 1'b0;
            if (g_r) rd_enable = 1'b0;
            if (g_f) fetch_enable = 1'b0;
            @(negedge CLK);
        end
        wr_enable = 1'b0; rd_enable = 1'b0; fetch_enable = 1'b0;
        check("t2_onehot", 32'(multi), 32'd0);
        check("t2_count", 32'(n), 32'd3);
        if (n == 3) begin
            check("t2_ord0", 32'(ord[0]), 32'(KW));
            check("t2_ord1", 32'(ord[1]), 32'(KR));
            check("t2_ord2", 32'(ord[2]), 32'(KF));
            check("t2_gap01", 32'(at[1] - at[0]), 32'd3);
            check("t2_gap12", 32'(at[2] - at[1]), 32'd3);
        end
        check("t2_rseen", 32'(rseen), 32'd1);
        check("t2_fseen", 32'(fseen), 32'd1);

        do_req(KR, 32'h0000_0102, '0, 1'b0, w);
        do_req(KR, 32'h0001_0000, '0, 1'b0, w);

        do_req(KR, 32'h40, '0, 1'b1, w);
        do_req(KW, 32'h40, 32'h0000_00AB, 1'b1, w);
        check("sc_write", tb_sram[16], 32'h0000_00AB);
        do_req(KW, 32'h40, 32'h0000_00CD, 1'b1, w);
        check("sc2_nowrite", tb_sram[16], 32'h0000_00AB);

        do_req(KR, 32'h40, '0, 1'b1, w);
        do_req(KW, 32'h40, 32'h1111_2222, 1'b0, w);
        do_req(KW, 32'h40, 32'h3333_4444, 1'b1, w);
        do_req(KR, 32'h40, '0, 1'b1, w);
        keep = tb_sram[17];
        do_req(KW, 32'h44, 32'h5555_6666, 1'b1, w);
        check("sc_other_nowrite", tb_sram[17], keep);

        // Reset during the ACCESS cycle of a store drops it without a response.
        wr_enable = 1'b1; wr_address = 32'h60; wr_data = 32'h7777_8888; wr_sc = 1'b0;
        #1;
        check("t6_ready", 32'(wr_ready), 32'd1);
        @(posedge CLK);
        #1;
        wr_enable = 1'b0;
        check("t6_access", 32'(sram_en), 32'd1);
        RESET = 1'b0;
        #1;
        check("t6_outs_zero", 32'(|{fetch_valid, fetch_inst, rd_valid, rd_data, wr_valid, wr_sc_fail,
              sram_en, sram_we, sram_addr, sram_wdata, wr_ready, rd_ready, fetch_ready}), 32'd0);
        ref_res_v = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        multi = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            if (fetch_valid || rd_valid || wr_valid) multi = 1'b1;
        end
        check("t6_no_valid", 32'(multi), 32'd0);
        check("t6_no_write", tb_sram[24], ref_mem[24]);
        do_req(KF, 32'h0000_0010, '0, 1'b0, w);

        for (int i = 0; i < 150; i++) begin
            int k;
            k = int'($urandom_range(0, 2));
            do_req(k, rand_addr(), $urandom, 1'($urandom_range(0, 1)), w);
        end

        diffs = 0;
        for (int i = 0; i < int'(WORDS); i++)
            if (tb_sram[i] !== ref_mem[i]) diffs++;
        check("mem_image", 32'(diffs), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
